au_arbiter: RTL

- Round-robin arbiter and sequencer that shares one sign-magnitude Arithmetic Unit (au: ADD/SUB/MUL/DIV) among NREQ requesters, e.g. the Kalman predict, update and gain engines.
- Accepts one operation per requester and drives the AU start/operand interface.
- Waits for the AU `done` pulse and returns the result to the granted requester.
- Only one AU operation is in flight at a time.

---
 rtl/au_arbiter_if.sv | 35 +++
 rtl/au_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/au_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : au_arbiter_if
// Purpose  : Start/operand/result bundle between the AU arbiter and the shared
//            sign-magnitude Arithmetic Unit. The arbiter is the master (drives
//            start and operands), the AU is the slave (returns done/result and
//            its reciprocal-busy indication).
// Revision : 1.0  initial release
// ============================================================================
interface au_arbiter_if #(
  parameter int W = 24
);
  // Arbiter -> AU
  logic         au_start;
  logic [1:0]   au_op;
  logic [1:0]   au_muly;
  logic [W-1:0] au_r;
  logic [W-1:0] au_s;
  logic [W-1:0] au_imm;
  // AU -> arbiter
  logic         au_done;
  logic [W-1:0] au_result;
  logic         au_busy;

  modport master (
    output au_start, au_op, au_muly, au_r, au_s, au_imm,
    input  au_done, au_result, au_busy
  );

  modport slave (
    input  au_start, au_op, au_muly, au_r, au_s, au_imm,
    output au_done, au_result, au_busy
  );
endinterface : au_arbiter_if
`default_nettype wire

// File: rtl/au_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : au_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one AU among NREQ
//            requesters. One operation in flight; operands are latched at
//            grant, the AU result is passed back unmodified to the winner.
// Options  : AU_ARB_TIMEOUT_EN - enables a WAIT-state watchdog of TO_CYC
//            cycles that answers with rsp_data=0, rsp_err=1.
// Revision : 1.0  initial release
// ============================================================================
module au_arbiter #(
  parameter int W      = 24,
  parameter int NREQ   = 4,
  parameter int TO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [2*NREQ-1:0] req_muly,
  input  logic [W*NREQ-1:0] req_r,
  input  logic [W*NREQ-1:0] req_s,
  input  logic [W*NREQ-1:0] req_imm,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  au_arbiter_if.master      au
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Reject configurations the pointer arithmetic was not written for.
  generate
    if (NREQ < 2 || NREQ > 8 || TO_CYC < 1) begin : g_bad_cfg
      $error("au_arbiter: unsupported NREQ or TO_CYC");
    end
  endgenerate

  // Per-requester views of the packed operand buses.
  logic [1:0]   op_a   [NREQ];
  logic [1:0]   muly_a [NREQ];
  logic [W-1:0] r_a    [NREQ];
  logic [W-1:0] s_a    [NREQ];
  logic [W-1:0] imm_a  [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign op_a[i]   = req_op[2*i +: 2];
      assign muly_a[i] = req_muly[2*i +: 2];
      assign r_a[i]    = req_r[W*i +: W];
      assign s_a[i]    = req_s[W*i +: W];
      assign imm_a[i]  = req_imm[W*i +: W];
    end
  endgenerate

  // (base + off) mod NREQ for off in 0..NREQ; NREQ need not be a power of 2.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[PW-1:0];
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            au_start_q, au_start_d;
  logic [1:0]      au_op_q, au_op_d;
  logic [1:0]      au_muly_q, au_muly_d;
  logic [W-1:0]    au_r_q, au_r_d;
  logic [W-1:0]    au_s_q, au_s_d;
  logic [W-1:0]    au_imm_q, au_imm_d;

`ifdef AU_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  logic            pick_found;
  logic [PW-1:0]   pick_idx;

  // Winner search: first requesting index at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req[wrap_add(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;          // response is a single-cycle pulse
    rsp_data_d  = rsp_data_q;  // result holds after the pulse
    au_start_d  = 1'b0;        // start is a single-cycle pulse
    au_op_d     = au_op_q;     // operands stay put until the next grant
    au_muly_d   = au_muly_q;
    au_r_d      = au_r_q;
    au_s_d      = au_s_q;
    au_imm_d    = au_imm_q;
`ifdef AU_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // An AU still busy (e.g. a DIV left over from before a reset) blocks
        // new issues so the shared unit is never started twice.
        if (pick_found && !au.au_busy) begin
          win_d      = pick_idx;
          gnt_d      = NREQ'(1) << pick_idx;
          au_op_d    = op_a[pick_idx];
          au_muly_d  = muly_a[pick_idx];
          au_r_d     = r_a[pick_idx];
          au_s_d     = s_a[pick_idx];
          au_imm_d   = imm_a[pick_idx];
          au_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d  = S_WAIT;
`ifdef AU_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        if (au.au_done) begin
          rsp_data_d  = au.au_result;
          rsp_valid_d = gnt_q;
`ifdef AU_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_RESP;
        end
`ifdef AU_ARB_TIMEOUT_EN
        else if (to_cnt_q == CW'(TO_CYC - 1)) begin
          // TO_CYC WAIT cycles without done: answer with an error result.
          rsp_data_d  = '0;
          rsp_valid_d = gnt_q;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          to_cnt_d    = to_cnt_q + 1'b1;
        end
`endif
      end

      S_RESP: begin
        gnt_d   = '0;
        ptr_d   = wrap_add(win_q, 1);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      au_start_q  <= 1'b0;
      au_op_q     <= '0;
      au_muly_q   <= '0;
      au_r_q      <= '0;
      au_s_q      <= '0;
      au_imm_q    <= '0;
`ifdef AU_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      au_start_q  <= au_start_d;
      au_op_q     <= au_op_d;
      au_muly_q   <= au_muly_d;
      au_r_q      <= au_r_d;
      au_s_q      <= au_s_d;
      au_imm_q    <= au_imm_d;
`ifdef AU_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != S_IDLE);
`ifdef AU_ARB_TIMEOUT_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

  assign au.au_start = au_start_q;
  assign au.au_op    = au_op_q;
  assign au.au_muly  = au_muly_q;
  assign au.au_r     = au_r_q;
  assign au.au_s     = au_s_q;
  assign au.au_imm   = au_imm_q;

endmodule : au_arbiter
`default_nettype wire
